// File: rtl/time_set_sequencer.sv
// rtl/time_set_sequencer.sv - time-set controller: walks hour/minute/second edit, commits with one load strobe
module time_set_sequencer #(
   parameter int HR_MAX    = 23,
   parameter int TIMEOUT_S = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [4:0] cur_hr,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   output logic [4:0] edit_hr,
   output logic [5:0] edit_min,
   output logic [5:0] edit_sec,
   output logic [1:0] field_sel,
   output logic       set_active,
   output logic       hold_count,
   output logic       ld_time,
   output logic       blink,
   output logic       timeout
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SET_HR  = 3'd1,
      SET_MIN = 3'd2,
      SET_SEC = 3'd3,
      COMMIT  = 3'd4
   } state_t;

   state_t     state, state_nx;
   logic [3:0] idle_cnt, idle_cnt_nx;
   logic [4:0] hr_nx;
   logic [5:0] min_nx, sec_nx;
   logic [1:0] field_sel_nx;
   logic       set_active_nx, ld_time_nx, blink_nx, timeout_nx;
   logic       in_set, nx_in_set;

   assign in_set     = (state == SET_HR) || (state == SET_MIN) || (state == SET_SEC);
   assign hold_count = set_active;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idle_cnt   <= 4'd0;
         edit_hr    <= 5'd0;
         edit_min   <= 6'd0;
         edit_sec   <= 6'd0;
         field_sel  <= 2'd0;
         set_active <= 1'b0;
         ld_time    <= 1'b0;
         blink      <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nx;
         idle_cnt   <= idle_cnt_nx;
         edit_hr    <= hr_nx;
         edit_min   <= min_nx;
         edit_sec   <= sec_nx;
         field_sel  <= field_sel_nx;
         set_active <= set_active_nx;
         ld_time    <= ld_time_nx;
         blink      <= blink_nx;
         timeout    <= timeout_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      idle_cnt_nx = idle_cnt;
      hr_nx       = edit_hr;
      min_nx      = edit_min;
      sec_nx      = edit_sec;
      timeout_nx  = 1'b0;

      case (state)
         IDLE: begin
            if (btn_mode) begin
               hr_nx       = cur_hr;
               min_nx      = cur_min;
               sec_nx      = cur_sec;
               idle_cnt_nx = 4'd0;
               state_nx    = SET_HR;
            end
         end
         SET_HR, SET_MIN, SET_SEC: begin
            // mode has priority; a simultaneous increment is dropped
            if (btn_mode) begin
               idle_cnt_nx = 4'd0;
               case (state)
                  SET_HR:  state_nx = SET_MIN;
                  SET_MIN: state_nx = SET_SEC;
                  default: state_nx = COMMIT;
               endcase
            end else if (btn_inc) begin
               idle_cnt_nx = 4'd0;
               case (state)
                  SET_HR:  hr_nx  = (edit_hr  >= 5'(HR_MAX)) ? 5'd0 : edit_hr  + 5'd1;
                  SET_MIN: min_nx = (edit_min >= 6'd59)      ? 6'd0 : edit_min + 6'd1;
                  default: sec_nx = (edit_sec >= 6'd59)      ? 6'd0 : edit_sec + 6'd1;
               endcase
            end else if (tick_1hz) begin
               if (idle_cnt == 4'(TIMEOUT_S - 1)) begin
                  state_nx    = IDLE;
                  timeout_nx  = 1'b1;
                  idle_cnt_nx = 4'd0;
               end else begin
                  idle_cnt_nx = idle_cnt + 4'd1;
               end
            end
         end
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // registered outputs are derived from the next state so they line up with it
   always_comb begin
      nx_in_set     = (state_nx == SET_HR) || (state_nx == SET_MIN) || (state_nx == SET_SEC);
      set_active_nx = (state_nx != IDLE);
      ld_time_nx    = (state_nx == COMMIT);
      field_sel_nx  = 2'd0;
      case (state_nx)
         SET_HR:  field_sel_nx = 2'd1;
         SET_MIN: field_sel_nx = 2'd2;
         SET_SEC: field_sel_nx = 2'd3;
         default: field_sel_nx = 2'd0;
      endcase
      blink_nx = blink;
      if (!nx_in_set)
         blink_nx = 1'b0;
      else if (state_nx != state)
         blink_nx = 1'b1;
      else if (in_set && tick_1hz)
         blink_nx = ~blink;
   end

endmodule

// File: tb/tb_time_set_sequencer.sv
// tb/tb_time_set_sequencer.sv - directed and randomized checks against a field-level reference model
module tb_time_set_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [4:0] cur_hr = 5'd0;
   logic [5:0] cur_min = 6'd0;
   logic [5:0] cur_sec = 6'd0;

   logic [4:0] edit_hr, edit_hr_b;
   logic [5:0] edit_min, edit_min_b, edit_sec, edit_sec_b;
   logic [1:0] field_sel, field_sel_b;
   logic       set_active, set_active_b, hold_count, hold_count_b;
   logic       ld_time, ld_time_b, blink, blink_b, timeout, timeout_b;

   int checks = 0;
   int errors = 0;

   // model: phase 0 idle, 1..3 editing hour/minute/second, 4 commit cycle
   int m_phase = 0;
   int m_hr[2] = '{0, 0};
   int m_min = 0;
   int m_sec = 0;
   int m_quiet = 0;
   int m_blink = 0;
   int m_to = 0;
   int hr_max[2] = '{23, 11};
   localparam int TMO = 10;

   always #5 clk = ~clk;

   time_set_sequencer dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
      .edit_hr(edit_hr), .edit_min(edit_min), .edit_sec(edit_sec), .field_sel(field_sel),
      .set_active(set_active), .hold_count(hold_count), .ld_time(ld_time), .blink(blink),
      .timeout(timeout)
   );

   time_set_sequencer #(.HR_MAX(11), .TIMEOUT_S(10)) dut12 (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
      .edit_hr(edit_hr_b), .edit_min(edit_min_b), .edit_sec(edit_sec_b), .field_sel(field_sel_b),
      .set_active(set_active_b), .hold_count(hold_count_b), .ld_time(ld_time_b), .blink(blink_b),
      .timeout(timeout_b)
   );

   function automatic int bump(input int v, input int top);
      return (v >= top) ? 0 : v + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit md, input bit inc, input bit tk, input bit r);
      m_to = 0;
      if (r) begin
         m_phase = 0; m_hr = '{0, 0}; m_min = 0; m_sec = 0; m_quiet = 0; m_blink = 0;
         return;
      end
      if (m_phase == 0) begin
         if (md) begin
            m_hr[0] = int'(cur_hr); m_hr[1] = int'(cur_hr);
            m_min = int'(cur_min); m_sec = int'(cur_sec);
            m_phase = 1; m_quiet = 0; m_blink = 1;
         end
      end else if (m_phase == 4) begin
         m_phase = 0;
      end else if (md) begin
         m_phase++; m_quiet = 0;
         m_blink = (m_phase == 4) ? 0 : 1;
      end else begin
         if (inc) begin
            m_quiet = 0;
            if (m_phase == 1) begin
               m_hr[0] = bump(m_hr[0], hr_max[0]);
               m_hr[1] = bump(m_hr[1], hr_max[1]);
            end else if (m_phase == 2) m_min = bump(m_min, 59);
            else m_sec = bump(m_sec, 59);
            if (tk) m_blink = 1 - m_blink;
         end else if (tk) begin
            m_quiet++;
            if (m_quiet >= TMO) begin
               m_phase = 0; m_to = 1; m_quiet = 0; m_blink = 0;
            end else m_blink = 1 - m_blink;
         end
      end
   endtask

   task automatic check_all();
      int fs;
      fs = (m_phase >= 1 && m_phase <= 3) ? m_phase : 0;
      chk("edit_hr", 32'(edit_hr), 32'(m_hr[0]));
      chk("edit_hr_h12", 32'(edit_hr_b), 32'(m_hr[1]));
      chk("edit_min", 32'(edit_min), 32'(m_min));
      chk("edit_sec", 32'(edit_sec), 32'(m_sec));
      chk("field_sel", 32'(field_sel), 32'(fs));
      chk("set_active", 32'(set_active), 32'(m_phase != 0));
      chk("hold_count", 32'(hold_count), 32'(m_phase != 0));
      chk("ld_time", 32'(ld_time), 32'(m_phase == 4));
      chk("blink", 32'(blink), 32'(m_blink));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("field_sel_h12", 32'(field_sel_b), 32'(fs));
   endtask

   task automatic step(input bit md, input bit inc, input bit tk, input bit r);
      btn_mode = md; btn_inc = inc; tick_1hz = tk; rst = r;
      @(posedge clk);
      #1;
      model_edge(md, inc, tk, r);
      check_all();
      btn_mode = 0; btn_inc = 0; tick_1hz = 0; rst = 0;
   endtask

   int ld_seen;
   int pm, pi, pt;

   initial begin
      // reset, then increments in idle are ignored
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      chk("idle_after_inc_hr", 32'(edit_hr), 32'd0);

      // full edit 12:34:56 -> 14:35:00
      cur_hr = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
      step(1, 0, 0, 0);
      chk("enter_active", 32'(set_active), 32'd1);
      step(0, 1, 0, 0); step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      chk("commit_ld", 32'(ld_time), 32'd1);
      chk("commit_val", {15'd0, edit_hr, edit_min, edit_sec}, {15'd0, 5'd14, 6'd35, 6'd0});
      step(0, 1, 0, 0);
      chk("after_commit_ld", 32'(ld_time), 32'd0);
      chk("after_commit_active", 32'(set_active), 32'd0);

      // hour wrap for both ranges
      cur_hr = 5'd23;
      step(1, 0, 0, 0); step(0, 1, 0, 0);
      chk("wrap23", 32'(edit_hr), 32'd0);
      chk("wrap_out_of_range_h12", 32'(edit_hr_b), 32'd0);
      step(0, 0, 0, 1);
      cur_hr = 5'd11;
      step(1, 0, 0, 0); step(0, 1, 0, 0);
      chk("wrap11_h12", 32'(edit_hr_b), 32'd0);
      chk("no_wrap11", 32'(edit_hr), 32'd12);

      // simultaneous mode and inc in minute field
      cur_min = 6'd62;
      step(0, 0, 0, 1);
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      chk("simul_field", 32'(field_sel), 32'd3);
      chk("simul_min", 32'(edit_min), 32'd62);

      // timeout after ten quiet ticks
      step(0, 0, 0, 1);
      step(1, 0, 0, 0);
      ld_seen = 0;
      for (int i = 1; i <= 10; i++) begin
         step(0, 0, 1, 0);
         if (ld_time) ld_seen++;
         if (i == 9) chk("tmo_not_yet", 32'(timeout), 32'd0);
      end
      chk("tmo_pulse", 32'(timeout), 32'd1);
      chk("tmo_idle", 32'(set_active), 32'd0);
      step(0, 0, 0, 0);
      chk("tmo_one_cycle", 32'(timeout), 32'd0);
      chk("tmo_no_ld", 32'(ld_seen), 32'd0);

      // inc on the 9th tick restarts the count
      step(1, 0, 0, 0);
      for (int i = 1; i <= 8; i++) step(0, 0, 1, 0);
      step(0, 1, 1, 0);
      for (int i = 1; i <= 9; i++) step(0, 0, 1, 0);
      chk("tmo_restart_pending", 32'(timeout), 32'd0);
      step(0, 0, 1, 0);
      chk("tmo_restart_pulse", 32'(timeout), 32'd1);

      // reset mid-edit
      step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
      chk("pre_rst_field", 32'(field_sel), 32'd3);
      step(0, 0, 0, 1);
      chk("rst_mid_vals", {15'd0, edit_hr, edit_min, edit_sec}, 32'd0);
      chk("rst_mid_ld", 32'(ld_time), 32'd0);

      // randomized phases with varying button/tick density
      for (int ph = 0; ph < 6; ph++) begin
         pm = (ph % 2 == 0) ? 8 : 40;
         pi = (ph % 2 == 0) ? 4 : 30;
         pt = (ph < 3) ? 5 : 2;
         for (int n = 0; n < 500; n++) begin
            cur_hr  = 5'($urandom_range(0, 31));
            cur_min = 6'($urandom_range(0, 63));
            cur_sec = 6'($urandom_range(0, 63));
            step(($urandom % pm) == 0, ($urandom % pi) == 0, ($urandom % pt) == 0,
                 ($urandom % 300) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/time_set_sequencer.md
Name: time_set_sequencer

Overview:
- FSM controller that sequences the clock's time-set datapath.
- Takes single-cycle mode/increment button pulses and walks the user through the hour, minute and second fields.
- Holds working copies of the three fields and freezes timekeeping while editing.
- Issues a single load strobe so the time registers commit all three edited fields at once; aborts without committing on inactivity.

Parameters:
- HR_MAX, 23, highest hour value; the hour field wraps HR_MAX->0 (set 11 for 0..11 operation).
- TIMEOUT_S, 10, number of tick_1hz pulses with no button activity before the edit is aborted (range 1..15).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-cycle pulse, once per second.
- btn_mode  input  1  one-cycle debounced pulse: enter set mode or advance to the next field.
- btn_inc  input  1  one-cycle debounced pulse: increment the selected field.
- cur_hr  input  5  current hour from the timekeeping registers.
- cur_min  input  6  current minute.
- cur_sec  input  6  current second.
- edit_hr  output  5  working hour value.
- edit_min  output  6  working minute value.
- edit_sec  output  6  working second value.
- field_sel  output  2  selected field: 0 none, 1 hour, 2 minute, 3 second.
- set_active  output  1  high in SET_HR, SET_MIN, SET_SEC and COMMIT.
- hold_count  output  1  freezes the timekeeping counter; equal to set_active.
- ld_time  output  1  one-cycle strobe that loads edit_* into the time registers.
- blink  output  1  display blink enable for the selected field.
- timeout  output  1  one-cycle pulse when an edit is aborted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - edit_*=0, field_sel=0, idle_cnt=0.
  - set_active=0, hold_count=0, ld_time=0, blink=0, timeout=0.
  - Reset mid-edit discards all edits; no ld_time is issued.
- States: IDLE, SET_HR, SET_MIN, SET_SEC, COMMIT. All outputs are registered.
- IDLE:
  - btn_mode=1 -> edit_hr<=cur_hr, edit_min<=cur_min, edit_sec<=cur_sec, then go to SET_HR.
  - btn_inc is ignored.
- Field advance: btn_mode moves SET_HR->SET_MIN->SET_SEC->COMMIT.
- Increment (btn_inc=1 and btn_mode=0) in a SET state:
  - SET_HR: edit_hr = (edit_hr>=HR_MAX) ? 0 : edit_hr+1.
  - SET_MIN: edit_min = (edit_min>=59) ? 0 : edit_min+1.
  - SET_SEC: edit_sec = (edit_sec>=59) ? 0 : edit_sec+1.
  - Out-of-range captured values (e.g. minute 62) go to 0 on the first increment.
- Simultaneous btn_mode and btn_inc: mode wins and the increment is dropped.
- COMMIT:
  - Lasts exactly one cycle with ld_time=1, then returns to IDLE.
  - edit_* stay stable during COMMIT and keep their values in IDLE.
  - Buttons in the COMMIT cycle are ignored.
- Latency:
  - btn_mode in IDLE -> set_active=1 on the next cycle.
  - btn_mode in SET_SEC -> ld_time=1 on the next cycle -> IDLE on the cycle after.
- field_sel: 1/2/3 in SET_HR/SET_MIN/SET_SEC; 0 in IDLE and COMMIT.
- Timeout:
  - idle_cnt (4-bit) clears on entry to SET_HR and on any button pulse.
  - In SET states, each tick_1hz without a button pulse in the same cycle increments idle_cnt.
  - When idle_cnt==TIMEOUT_S-1 and such a tick arrives -> IDLE, timeout=1 for one cycle, ld_time stays 0.
  - A button and a tick in the same cycle: the button takes effect and the counter clears.
- blink:
  - Set to 1 on entry to SET_HR and on each field advance.
  - Toggles on each tick_1hz in SET states.
  - Forced to 0 in IDLE and COMMIT.
- hold_count == set_active at all times.

Test Plan:
- Reset then idle: rst for 2 cycles, pulse btn_inc ×3 -> all outputs 0, state IDLE, edit_* unchanged at 0.
- Full edit: cur=12:34:56, mode, inc×2, mode, inc×1, mode, inc×4, mode -> ld_time one cycle with edit=14:35:00 (sec 56+4 wraps to 0), then IDLE.
- Wrap: cur_hr=23, mode, inc -> edit_hr=0; with HR_MAX=11 and cur_hr=11 -> 0.
- Simultaneous: in SET_MIN, btn_mode and btn_inc in the same cycle -> go to SET_SEC, edit_min unchanged.
- Timeout: enter SET_HR, apply 10 tick_1hz with no buttons -> timeout pulse on the 10th, IDLE, ld_time never asserted. With an inc at tick 9, the abort occurs only 10 ticks after that inc.
- Reset mid-edit: in SET_SEC assert rst -> next cycle IDLE, edit_*=0, no ld_time.
